// File: rtl/fifo_rd_stream.sv
// Read-side controller for the synchronous FIFO. It issues reads, catches the
// 1-cycle-late read data in a 3-entry skid buffer and presents it as a valid/ready stream.
// Define FIFO_RD_STREAM_CNT_EN to add the rd_count accepted-transfer counter.
module fifo_rd_stream #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [CNT_W-1:0] rd_count
`endif
);

  logic [1:0]       occ;
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;
  logic             inflight;
  logic [WIDTH-1:0] mem [3];
  logic [2:0]       committed;
  logic             pop;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A read is issued only when the word it returns is guaranteed a free slot.
  // Buffered plus in-flight words are counted, so out_ready never reaches fifo_rd_en.
  assign committed  = {1'b0, occ} + {2'b00, inflight};
  assign fifo_rd_en = !rst && !fifo_empty && (committed < 3'd3);

  assign out_valid = (occ != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      for (int i = 0; i < 3; i++) mem[i] <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (inflight) begin
        mem[wr_ptr] <= fifo_rdata;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({inflight, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

`ifdef FIFO_RD_STREAM_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) rd_count <= '0;
    else if (pop) rd_count <= rd_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a behavioural FIFO feeds the DUT, and a queue-based
// stream model is compared against the DUT outputs on every falling edge.
module tb_fifo_rd_stream;

  localparam int WIDTH = 32;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_rdata = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
`ifdef FIFO_RD_STREAM_CNT_EN
  logic [CNT_W-1:0] rd_count;
`endif

  fifo_rd_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_rdata (fifo_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    .rd_count   (rd_count)
`endif
  );

  always #5 clk = ~clk;

  // Upstream FIFO: stimulus appends at tail, reads pop at head with 1-cycle data latency.
  logic [WIDTH-1:0] fmem [0:2047];
  int head = 0;
  int tail = 0;
  int cyc  = 0;

  assign fifo_empty = (head == tail);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) begin
      fifo_rdata <= fmem[head];
      head       <= head + 1;
    end
  end

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [63:0] act;
    logic [63:0] exp;
  } lit_t;
  lit_t lit_arr [0:255];
  int   lit_wr = 0;
  int   lit_rd = 0;

  logic [WIDTH-1:0] emitted [$];
  int               pop_cyc [$];
  int               rd_cyc  [$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Stream model: a queue of buffered words plus one pending read, advanced by the rules alone.
  logic [WIDTH-1:0] mq [$];
  bit               m_inflight = 1'b0;
  logic [WIDTH-1:0] m_word = '0;
  logic [CNT_W-1:0] m_count = '0;

  initial begin
    bit exp_rd;
    forever begin
      @(negedge clk);
      exp_rd = !rst && (head != tail) && ((mq.size() + int'(m_inflight)) < 3);
      checkOutput("fifo_rd_en", {63'd0, fifo_rd_en}, {63'd0, exp_rd});
      checkOutput("out_valid", {63'd0, out_valid}, {63'd0, mq.size() != 0});
      if (mq.size() != 0) checkOutput("out_data", 64'(out_data), 64'(mq[0]));
      checkOutput("rd_en_while_empty", {63'd0, fifo_rd_en && fifo_empty}, 64'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
      checkOutput("rd_count", 64'(rd_count), 64'(m_count));
`endif
      while (lit_rd < lit_wr) begin
        checkOutput(lit_arr[lit_rd].name, lit_arr[lit_rd].act, lit_arr[lit_rd].exp);
        lit_rd++;
      end

      if (fifo_rd_en) rd_cyc.push_back(cyc);
      if (!rst && out_valid && out_ready) begin
        emitted.push_back(out_data);
        pop_cyc.push_back(cyc);
      end

      if (rst) begin
        mq.delete();
        m_inflight = 1'b0;
        m_count    = '0;
      end else begin
        if (mq.size() != 0 && out_ready) begin
          void'(mq.pop_front());
          m_count = m_count + 1'b1;
        end
        if (m_inflight) mq.push_back(m_word);
        m_inflight = exp_rd;
        if (exp_rd) m_word = fmem[head];
      end
    end
  end

  task automatic postCheck(input string name, input logic [63:0] act, input logic [63:0] exp);
    lit_arr[lit_wr].name = name;
    lit_arr[lit_wr].act  = act;
    lit_arr[lit_wr].exp  = exp;
    lit_wr++;
  endtask

  task automatic applyStimulus(input bit r, input bit ready);
    @(posedge clk);
    #1;
    rst       = r;
    out_ready = ready;
  endtask

  task automatic pushWord(input logic [WIDTH-1:0] v);
    fmem[tail] = v;
    tail++;
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic sampleNow();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int e0, r0, base, errs, n;

    // Idle: empty FIFO after reset must never be read.
    doReset();
    r0 = rd_cyc.size();
    repeat (10) applyStimulus(1'b0, 1'b0);
    sampleNow();
    postCheck("idle_reads", 64'(rd_cyc.size() - r0), 64'd0);
    postCheck("idle_valid", {63'd0, out_valid}, 64'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
    postCheck("idle_count", 64'(rd_count), 64'd0);
`endif

    // Burst of 8 with the consumer always ready.
    doReset();
    out_ready = 1'b1;
    e0 = emitted.size();
    r0 = rd_cyc.size();
    for (int i = 0; i < 8; i++) pushWord(32'h10 + i);
    repeat (16) applyStimulus(1'b0, 1'b1);
    sampleNow();
    postCheck("burst_count", 64'(emitted.size() - e0), 64'd8);
    if (emitted.size() - e0 == 8) begin
      postCheck("burst_latency", 64'(pop_cyc[e0] - rd_cyc[r0]), 64'd2);
      postCheck("burst_back_to_back", 64'(pop_cyc[e0 + 7] - pop_cyc[e0]), 64'd7);
      errs = 0;
      for (int i = 0; i < 8; i++) if (emitted[e0 + i] !== 32'h10 + i) errs++;
      postCheck("burst_order", 64'(errs), 64'd0);
    end
`ifdef FIFO_RD_STREAM_CNT_EN
    postCheck("burst_rd_count", 64'(rd_count), 64'd8);
`endif

    // Backpressure: only three reads may be outstanding while the consumer stalls.
    doReset();
    e0 = emitted.size();
    r0 = rd_cyc.size();
    for (int i = 0; i < 8; i++) pushWord(32'h10 + i);
    repeat (12) applyStimulus(1'b0, 1'b0);
    sampleNow();
    postCheck("bp_reads", 64'(rd_cyc.size() - r0), 64'd3);
    postCheck("bp_valid", {63'd0, out_valid}, 64'd1);
    postCheck("bp_data_held", 64'(out_data), 64'h10);
    repeat (20) applyStimulus(1'b0, 1'b1);
    sampleNow();
    postCheck("bp_count", 64'(emitted.size() - e0), 64'd8);
    if (emitted.size() - e0 == 8) begin
      errs = 0;
      for (int i = 0; i < 8; i++) if (emitted[e0 + i] !== 32'h10 + i) errs++;
      postCheck("bp_order", 64'(errs), 64'd0);
    end

    // FIFO runs dry mid-burst, third word arrives five cycles later.
    doReset();
    out_ready = 1'b1;
    e0 = emitted.size();
    r0 = rd_cyc.size();
    pushWord(32'h20);
    pushWord(32'h21);
    repeat (5) applyStimulus(1'b0, 1'b1);
    pushWord(32'h22);
    repeat (10) applyStimulus(1'b0, 1'b1);
    sampleNow();
    postCheck("dry_reads", 64'(rd_cyc.size() - r0), 64'd3);
    postCheck("dry_count", 64'(emitted.size() - e0), 64'd3);
    if (emitted.size() - e0 == 3) begin
      postCheck("dry_w0", 64'(emitted[e0]), 64'h20);
      postCheck("dry_w1", 64'(emitted[e0 + 1]), 64'h21);
      postCheck("dry_w2", 64'(emitted[e0 + 2]), 64'h22);
    end

    // Reset with two words buffered and one in flight: 0x30..0x32 are lost.
    doReset();
    e0 = emitted.size();
    for (int i = 0; i < 5; i++) pushWord(32'h30 + i);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    sampleNow();
    postCheck("rst_rd_en_forced", {63'd0, fifo_rd_en}, 64'd0);
    postCheck("rst_pre_valid", {63'd0, out_valid}, 64'd1);
    applyStimulus(1'b1, 1'b0);
    sampleNow();
    postCheck("rst_valid_cleared", {63'd0, out_valid}, 64'd0);
    postCheck("rst_data_cleared", 64'(out_data), 64'd0);
    repeat (15) applyStimulus(1'b0, 1'b1);
    sampleNow();
    postCheck("rst_survivors", 64'(emitted.size() - e0), 64'd2);
    if (emitted.size() - e0 == 2) begin
      postCheck("rst_w0", 64'(emitted[e0]), 64'h33);
      postCheck("rst_w1", 64'(emitted[e0 + 1]), 64'h34);
    end

    // 1000 random words with a coin-flip consumer.
    doReset();
    e0   = emitted.size();
    base = tail;
    for (int i = 0; i < 1000; i++) pushWord($urandom);
    n = 0;
    while ((emitted.size() - e0 < 1000) && (n < 6000)) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)));
      n++;
    end
    sampleNow();
    postCheck("rand_count", 64'(emitted.size() - e0), 64'd1000);
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      if (e0 + i >= emitted.size()) errs++;
      else if (emitted[e0 + i] !== fmem[base + i]) errs++;
    end
    postCheck("rand_order", 64'(errs), 64'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
    postCheck("rand_rd_count", 64'(rd_count), 64'd1000);
`endif

    repeat (3) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
